// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding N_REQ writers into one FIFO; write strobe lags accept by 1 cycle.
// Backpressure: ready drops while FIFO full/almost-full, grant held. Optional stats: FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DWIDTH    = 64,
   parameter int MAX_BURST = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [N_REQ*DWIDTH-1:0]   req_data_i,
   input  logic [N_REQ-1:0]          req_valid_i,
   output logic [N_REQ-1:0]          req_ready_o,
   output logic [DWIDTH-1:0]         fifo_data_o,
   output logic                      fifo_wrreq_o,
   input  logic                      fifo_full_i,
   input  logic                      fifo_almost_full_i,
   output logic [N_REQ-1:0]          grant_o
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [N_REQ*32-1:0]       word_cnt_o
`endif
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [IW-1:0]       gidx_q, gidx_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [DWIDTH-1:0]   data_q, data_d;
   logic                wr_q, wr_d;
   logic                init_q;

   logic                space_ok;
   logic                accept;
   logic                last_word;
   logic                pick_vld;
   logic [IW-1:0]       pick_idx;
   logic [DWIDTH-1:0]   gword;

   assign space_ok  = !fifo_full_i && !fifo_almost_full_i;
   assign gword     = req_data_i[gidx_q*DWIDTH +: DWIDTH];
   assign accept    = (state_q == BURST) && req_valid_i[gidx_q] && space_ok;
   assign last_word = (cnt_q == 8'(MAX_BURST - 1));

   // Search starts one past the last granted index so every requester gets its turn.
   always_comb begin
      int c;
      c        = 0;
      pick_vld = 1'b0;
      pick_idx = gidx_q;
      for (int i = 1; i <= N_REQ; i++) begin
         c = int'(gidx_q) + i;
         if (c >= N_REQ) c = c - N_REQ;
         if (!pick_vld && req_valid_i[IW'(c)]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(c);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      wr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            // init_q keeps the first post-reset edge grant-free.
            if (init_q && pick_vld) begin
               state_d = BURST;
               grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
               gidx_d  = pick_idx;
               cnt_d   = 8'd0;
            end
         end
         BURST: begin
            if (accept) begin
               wr_d   = 1'b1;
               data_d = gword;
               cnt_d  = cnt_q + 8'd1;
            end
            if (!req_valid_i[gidx_q] || (accept && last_word)) begin
               state_d = IDLE;
               grant_d = '0;
               cnt_d   = 8'd0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= IW'(N_REQ - 1);
         cnt_q   <= 8'd0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         init_q  <= 1'b1;
      end
   end

   assign req_ready_o  = grant_q & {N_REQ{space_ok}};
   assign grant_o      = grant_q;
   assign fifo_data_o  = data_q;
   assign fifo_wrreq_o = wr_q;

`ifdef FIFO_WR_ARB_STATS_EN
   for (genvar k = 0; k < N_REQ; k++) begin : g_stats
      logic [31:0] wcnt_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            wcnt_q <= 32'd0;
         end else if (accept && (gidx_q == IW'(k)) && (wcnt_q != 32'hFFFF_FFFF)) begin
            wcnt_q <= wcnt_q + 32'd1;
         end
      end
      assign word_cnt_o[k*32 +: 32] = wcnt_q;
   end
`endif

endmodule
